// File: rtl/uart_pkg.sv
// Shared definitions for the UART receive path: byte width, bit-FSM states,
// and a counter-width helper.
package uart_pkg;

    localparam int UART_DATA_BIT = 8;

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        STOP,
        BREAK
    } rx_state_e;

    // Bits needed to hold values 0..max_val; never less than one bit.
    function automatic int cnt_w(input int max_val);
        return (max_val < 2) ? 1 : $clog2(max_val + 1);
    endfunction

endpackage

// File: rtl/uart_rx.sv
// Bit-level 8N1 receiver: 2-flop synchronizer plus IDLE/START/DATA/STOP/BREAK FSM.
// Emits single-cycle byte_valid / frame_error strobes in the stop-sample cycle.
module uart_rx
    import uart_pkg::*;
#(
    parameter int CLOCK_PER_BIT = 1000
) (
    input  logic                     clk,
    input  logic                     a_reset_n,
    input  logic                     uart_in,
    output logic                     byte_valid,
    output logic [UART_DATA_BIT-1:0] byte_data,
    output logic                     frame_error,
    output logic                     rx_idle
);

    localparam int CW = cnt_w(CLOCK_PER_BIT - 1);
    localparam int BW = cnt_w(UART_DATA_BIT - 1);
    localparam logic [CW-1:0] HALF_M1  = CW'(CLOCK_PER_BIT / 2 - 1);
    localparam logic [CW-1:0] FULL_M1  = CW'(CLOCK_PER_BIT - 1);
    localparam logic [BW-1:0] LAST_BIT = BW'(UART_DATA_BIT - 1);

    logic [1:0]               sync_q;
    logic                     prev_q;
    rx_state_e                state_q, state_d;
    logic [CW-1:0]            cnt_q, cnt_d;
    logic [BW-1:0]            bit_q, bit_d;
    logic [UART_DATA_BIT-1:0] shreg_q, shreg_d;
    logic                     rx;

    assign rx        = sync_q[1];
    assign byte_data = shreg_q;
    assign rx_idle   = (state_q == IDLE);

    always_ff @(posedge clk or negedge a_reset_n) begin
        if (!a_reset_n) begin
            sync_q  <= 2'b11;
            prev_q  <= 1'b1;
            state_q <= IDLE;
            cnt_q   <= '0;
            bit_q   <= '0;
            shreg_q <= '0;
        end else begin
            sync_q  <= {sync_q[0], uart_in};
            prev_q  <= rx;
            state_q <= state_d;
            cnt_q   <= cnt_d;
            bit_q   <= bit_d;
            shreg_q <= shreg_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        bit_d       = bit_q;
        shreg_d     = shreg_q;
        byte_valid  = 1'b0;
        frame_error = 1'b0;
        case (state_q)
            IDLE: begin
                if (prev_q && !rx) begin
                    state_d = START;
                    cnt_d   = '0;
                end
            end
            START: begin
                if (cnt_q == HALF_M1) begin
                    cnt_d   = '0;
                    bit_d   = '0;
                    // A line already back high at mid start bit was only a glitch.
                    state_d = rx ? IDLE : DATA;
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
            DATA: begin
                if (cnt_q == FULL_M1) begin
                    cnt_d   = '0;
                    shreg_d = {rx, shreg_q[UART_DATA_BIT-1:1]};
                    if (bit_q == LAST_BIT) begin
                        bit_d   = '0;
                        state_d = STOP;
                    end else begin
                        bit_d = bit_q + BW'(1);
                    end
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
            STOP: begin
                if (cnt_q == FULL_M1) begin
                    cnt_d = '0;
                    if (rx) begin
                        byte_valid = 1'b1;
                        state_d    = IDLE;
                    end else begin
                        frame_error = 1'b1;
                        state_d     = BREAK;
                    end
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
            BREAK: begin
                if (rx) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

endmodule

// File: rtl/uart_rx_top.sv
// UART receiver packing bytes MSB-first into DATA_WIDTH-bit words.
// Optional partial-word idle timeout enabled by defining UART_RX_TIMEOUT_EN.
module uart_rx_top
    import uart_pkg::*;
#(
    parameter int DATA_WIDTH    = 16,
    parameter int CLOCK_PER_BIT = 1000,
    parameter int TIMEOUT_BITS  = 32
) (
    input  logic                  clk,
    input  logic                  a_reset_n,
    input  logic                  uart_in,
    output logic                  data_valid,
    output logic [DATA_WIDTH-1:0] data_out,
    output logic                  frame_error,
    output logic                  timeout
);

    localparam int NBYTES = DATA_WIDTH / UART_DATA_BIT;
    localparam int BCW    = cnt_w(NBYTES - 1);
    localparam logic [BCW-1:0] LAST_BYTE = BCW'(NBYTES - 1);

    logic                     rx_bvalid, rx_ferr, rx_idle;
    logic [UART_DATA_BIT-1:0] rx_byte;

    logic [DATA_WIDTH-1:0] word_q, word_d, word_shift;
    logic [BCW-1:0]        bcnt_q, bcnt_d;
    logic [DATA_WIDTH-1:0] dout_q, dout_d;
    logic                  dv_q, dv_d, fe_q, fe_d, to_q, to_d;
    logic                  tout_hit;

    uart_rx #(
        .CLOCK_PER_BIT(CLOCK_PER_BIT)
    ) u_rx (
        .clk        (clk),
        .a_reset_n  (a_reset_n),
        .uart_in    (uart_in),
        .byte_valid (rx_bvalid),
        .byte_data  (rx_byte),
        .frame_error(rx_ferr),
        .rx_idle    (rx_idle)
    );

    generate
        if (NBYTES == 1) begin : g_single
            assign word_shift = rx_byte;
        end else begin : g_multi
            assign word_shift = {word_q[DATA_WIDTH-UART_DATA_BIT-1:0], rx_byte};
        end
    endgenerate

`ifdef UART_RX_TIMEOUT_EN
    localparam int TO_MAX = TIMEOUT_BITS * CLOCK_PER_BIT;
    localparam int ICW    = cnt_w(TO_MAX - 1);

    logic [ICW-1:0] idle_q, idle_d;

    // Any start edge leaves IDLE, which clears the count on the next cycle.
    assign tout_hit = rx_idle && (bcnt_q != '0) && (idle_q == ICW'(TO_MAX - 1));

    always_comb begin
        idle_d = '0;
        if (rx_idle && (bcnt_q != '0) && !tout_hit) idle_d = idle_q + ICW'(1);
    end

    always_ff @(posedge clk or negedge a_reset_n) begin
        if (!a_reset_n) idle_q <= '0;
        else            idle_q <= idle_d;
    end
`else
    logic unused_idle;
    assign unused_idle = rx_idle;
    assign tout_hit    = 1'b0;
`endif

    always_comb begin
        word_d = word_q;
        bcnt_d = bcnt_q;
        dout_d = dout_q;
        dv_d   = 1'b0;
        fe_d   = rx_ferr;
        to_d   = 1'b0;
        if (rx_ferr) begin
            word_d = '0;
            bcnt_d = '0;
        end else if (rx_bvalid) begin
            word_d = word_shift;
            if (bcnt_q == LAST_BYTE) begin
                dout_d = word_shift;
                dv_d   = 1'b1;
                bcnt_d = '0;
            end else begin
                bcnt_d = bcnt_q + BCW'(1);
            end
        end else if (tout_hit) begin
            word_d = '0;
            bcnt_d = '0;
            to_d   = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge a_reset_n) begin
        if (!a_reset_n) begin
            word_q <= '0;
            bcnt_q <= '0;
            dout_q <= '0;
            dv_q   <= 1'b0;
            fe_q   <= 1'b0;
            to_q   <= 1'b0;
        end else begin
            word_q <= word_d;
            bcnt_q <= bcnt_d;
            dout_q <= dout_d;
            dv_q   <= dv_d;
            fe_q   <= fe_d;
            to_q   <= to_d;
        end
    end

    assign data_valid  = dv_q;
    assign data_out    = dout_q;
    assign frame_error = fe_q;
    assign timeout     = to_q;

endmodule

// File: tb/tb_uart_rx_top.sv
// Self-checking bench for uart_rx_top (DATA_WIDTH=16, CLOCK_PER_BIT=16).
// Exercises the UART_RX_TIMEOUT_EN path when that macro is defined.
module tb_uart_rx_top;

    localparam int DW  = 16;
    localparam int CPB = 16;
    localparam int TOB = 4;
    localparam int LAT = 2 + CPB / 2 + 9 * CPB + 1;

    logic          clk = 1'b0;
    logic          a_reset_n = 1'b0;
    logic          uart_in = 1'b1;
    logic          data_valid, frame_error, timeout;
    logic [DW-1:0] data_out;

    uart_rx_top #(
        .DATA_WIDTH   (DW),
        .CLOCK_PER_BIT(CPB),
        .TIMEOUT_BITS (TOB)
    ) dut (
        .clk        (clk),
        .a_reset_n  (a_reset_n),
        .uart_in    (uart_in),
        .data_valid (data_valid),
        .data_out   (data_out),
        .frame_error(frame_error),
        .timeout    (timeout)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int nvec = 0, nerr = 0;
    int nvld = 0, nfe = 0, nto = 0, nclash = 0;
    int last_start = 0;
    logic [DW-1:0] got_q[$];
    int            got_cyc[$];

    always @(negedge clk) begin
        if (a_reset_n) begin
            if (data_valid) begin
                got_q.push_back(data_out);
                got_cyc.push_back(cyc);
                nvld++;
            end
            if (frame_error) nfe++;
            if (timeout) nto++;
            if (int'(data_valid) + int'(frame_error) + int'(timeout) > 1) nclash++;
        end
    end

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        nvec++;
        if (act !== exp) begin
            nerr++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    // Caller is at a negedge; every segment ends on a negedge so frames chain with no gap.
    task automatic send_byte(input logic [7:0] b, input int stop_low);
        uart_in    = 1'b0;
        last_start = cyc;
        repeat (CPB) @(negedge clk);
        for (int i = 0; i < 8; i++) begin
            uart_in = b[i];
            repeat (CPB) @(negedge clk);
        end
        if (stop_low > 0) begin
            uart_in = 1'b0;
            repeat (stop_low) @(negedge clk);
        end
        uart_in = 1'b1;
        repeat (CPB) @(negedge clk);
    endtask

    task automatic idle(input int n);
        uart_in = 1'b1;
        repeat (n) @(negedge clk);
    endtask

    task automatic expect_word(input string nm, input logic [DW-1:0] exp, input bit chk_lat);
        int t = 0;
        int lat;
        while (got_q.size() == 0 && t < 4000) begin
            @(negedge clk);
            t++;
        end
        if (got_q.size() == 0) begin
            nvec++;
            nerr++;
            $display("FAIL %s: no data_valid within %0d cycles, expected %0h", nm, t, exp);
        end else begin
            chk(nm, 32'(got_q.pop_front()), 32'(exp));
            lat = got_cyc.pop_front() - last_start;
            if (chk_lat) begin
                nvec++;
                if (lat < LAT - 1 || lat > LAT + 1) begin
                    nerr++;
                    $display("FAIL %s_latency: got %0d expected %0d+-1", nm, lat, LAT);
                end
            end
        end
    endtask

    typedef struct {
        logic [7:0]    b0;
        logic [7:0]    b1;
        int            gap;
        logic [DW-1:0] exp;
    } vec_t;

    vec_t          tbl[4];
    logic [7:0]    rnd_bytes[$];
    logic [DW-1:0] model_q[$];

    initial begin
        int nv0, fe0, to0;

        tbl[0] = '{8'hA5, 8'h3C, 0,  16'hA53C};
        tbl[1] = '{8'h00, 8'hFF, 5,  16'h00FF};
        tbl[2] = '{8'hFF, 8'h00, 20, 16'hFF00};
        tbl[3] = '{8'h80, 8'h01, 40, 16'h8001};

        // Reset state
        repeat (3) @(negedge clk);
        chk("rst_data_valid", 32'(data_valid), 0);
        chk("rst_data_out", 32'(data_out), 0);
        chk("rst_frame_error", 32'(frame_error), 0);
        chk("rst_timeout", 32'(timeout), 0);
        a_reset_n = 1'b1;
        idle(2 * CPB);

        // Table-driven word pairs with varying inter-byte gaps
        for (int i = 0; i < 4; i++) begin
            send_byte(tbl[i].b0, 0);
            idle(tbl[i].gap);
            send_byte(tbl[i].b1, 0);
            expect_word($sformatf("tbl%0d", i), tbl[i].exp, 1'b1);
            idle(CPB);
        end
        chk("tbl_no_frame_error", 32'(nfe), 0);

        // Short low glitch must not start a frame
        nv0 = nvld;
        fe0 = nfe;
        uart_in = 1'b0;
        repeat (6) @(negedge clk);
        idle(3 * CPB);
        chk("glitch_no_valid", 32'(nvld), 32'(nv0));
        chk("glitch_no_ferr", 32'(nfe), 32'(fe0));
        send_byte(8'h12, 0);
        send_byte(8'h34, 0);
        expect_word("after_glitch", 16'h1234, 1'b0);
        idle(CPB);

        // Stop bit held low for two bit-times: byte dropped, word realigns
        fe0 = nfe;
        send_byte(8'h55, 2 * CPB);
        idle(CPB);
        chk("ferr_pulse", 32'(nfe), 32'(fe0 + 1));
        send_byte(8'hAA, 0);
        send_byte(8'hBB, 0);
        expect_word("after_ferr", 16'hAABB, 1'b0);
        chk("ferr_no_stale", 32'(got_q.size()), 0);
        idle(CPB);

        // Reset in the middle of bit 4 of the second byte
        send_byte(8'hA5, 0);
        uart_in = 1'b0;
        repeat (CPB) @(negedge clk);
        for (int i = 0; i < 4; i++) begin
            uart_in = i[0];
            repeat (CPB) @(negedge clk);
        end
        uart_in = 1'b1;
        repeat (CPB / 2) @(negedge clk);
        nv0 = nvld;
        a_reset_n = 1'b0;
        repeat (2) @(negedge clk);
        chk("midrst_data_valid", 32'(data_valid), 0);
        chk("midrst_data_out", 32'(data_out), 0);
        chk("midrst_frame_error", 32'(frame_error), 0);
        chk("midrst_timeout", 32'(timeout), 0);
        a_reset_n = 1'b1;
        idle(2 * CPB);
        chk("midrst_no_strobe", 32'(nvld), 32'(nv0));
        send_byte(8'hDE, 0);
        send_byte(8'hAD, 0);
        expect_word("after_reset", 16'hDEAD, 1'b0);
        chk("midrst_no_stale", 32'(got_q.size()), 0);
        idle(CPB);

        // Ten words with zero idle between frames
        nv0 = nvld;
        for (int w = 1; w <= 10; w++) begin
            send_byte(8'h00, 0);
            send_byte(8'(w), 0);
        end
        chk("b2b_count", 32'(nvld - nv0), 10);
        for (int w = 1; w <= 10; w++) expect_word($sformatf("b2b%0d", w), 16'(w), 1'b0);
        idle(CPB);

        // Random bytes with random gaps; model pairs bytes MSB-first
        for (int i = 0; i < 16; i++) rnd_bytes.push_back(8'($urandom));
        for (int i = 0; i < 16; i += 2) model_q.push_back({rnd_bytes[i], rnd_bytes[i+1]});
        for (int i = 0; i < 16; i++) begin
            send_byte(rnd_bytes[i], 0);
            idle($urandom_range(0, 2 * CPB));
        end
        while (model_q.size() > 0) expect_word("rand", model_q.pop_front(), 1'b0);
        idle(CPB);

`ifdef UART_RX_TIMEOUT_EN
        to0 = nto;
        send_byte(8'h11, 0);
        idle(5 * CPB);
        chk("timeout_pulse", 32'(nto), 32'(to0 + 1));
        send_byte(8'h22, 0);
        send_byte(8'h33, 0);
        expect_word("after_timeout", 16'h2233, 1'b0);
`else
        to0 = nto;
        send_byte(8'h11, 0);
        idle(5 * CPB);
        chk("no_timeout", 32'(nto), 32'(to0));
        send_byte(8'h22, 0);
        expect_word("partial_kept", 16'h1122, 1'b0);
`endif
        idle(CPB);
        chk("strobe_exclusive", 32'(nclash), 0);
        chk("no_extra_words", 32'(got_q.size()), 0);

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end

endmodule

// File: doc/uart_rx_top.md
Name: uart_rx_top

Overview:
Receive-side counterpart of the word-to-byte UART transmit path. Samples a serial 8N1 UART line, recovers bytes, and packs consecutive bytes MSB-first into DATA_WIDTH-bit words. The first byte received fills the most-significant byte of the word. Each completed word is presented to user logic with a one-cycle valid strobe. Sits between the board UART RX pin and user logic; pairs with the transmit block at the far end of the link.

Parameters:
DATA_WIDTH, 16, output word width; integer multiple of 8, minimum 8.
CLOCK_PER_BIT, 1000, clk cycles per UART bit (baud = clk rate / CLOCK_PER_BIT); minimum 4.
TIMEOUT_BITS, 32, idle bit-times before a partial word is discarded (used only with UART_RX_TIMEOUT_EN).

Ports:
clk  input  1  system clock; all logic is on the rising edge.
a_reset_n  input  1  asynchronous reset, active-low.
uart_in  input  1  serial line; idles high; asynchronous to clk.
data_valid  output  1  one-cycle strobe when data_out holds a new word.
data_out  output  DATA_WIDTH  last completed word; held until the next word completes.
frame_error  output  1  one-cycle strobe when a byte's stop bit is sampled low.
timeout  output  1  one-cycle strobe when a partial word is discarded; tied 0 without the macro.

Behaviour:
- Clock and reset are fixed: one clock, clk. Reset a_reset_n is asynchronous and active-low.
- Reset values: data_valid=0, data_out=0, frame_error=0, timeout=0. Synchronizer flops reset to 1 (idle line). FSM resets to IDLE; byte count=0; bit counter=0.
- uart_in passes through a 2-flop synchronizer. All sampling uses the synchronized value.
- Bit-level FSM states and transitions:
  - IDLE: a synchronized 1->0 transition moves to START and clears the cycle counter.
  - START: at count CLOCK_PER_BIT/2-1 (integer division), sample the line. Low: go to DATA. High: treat as a glitch and return to IDLE with no output.
  - DATA: sample every CLOCK_PER_BIT cycles. 8 bits, LSB first, shifted into the byte register. After bit 7, go to STOP.
  - STOP: sample after CLOCK_PER_BIT cycles (mid stop bit).
    - High: byte is good; return to IDLE.
    - Low: pulse frame_error, drop the byte, clear the partial word and byte count, go to BREAK.
  - BREAK: wait for the synchronized line to be high, then go to IDLE.
- Word packing:
  - Each good byte is shifted into the word shift register at the LSB end; earlier bytes move toward the MSB.
  - The byte count increments per good byte.
  - When the count reaches DATA_WIDTH/8: load data_out with the full word, pulse data_valid for one cycle (the cycle after the stop sample), and reset the count to 0.
  - DATA_WIDTH=8 yields one word per byte.
- Latency: data_valid rises 2 (synchronizer) + CLOCK_PER_BIT/2 + 9*CLOCK_PER_BIT + 1 cycles after the start-bit falling edge of the last byte, within ±1 cycle.
- Back-to-back bytes: a start edge is accepted the first cycle IDLE is re-entered after the stop sample. No extra idle time is required.
- data_valid, frame_error and timeout never assert in the same cycle.
- Reset mid-frame: everything returns to reset values immediately. The partial byte and word are lost. No strobe fires on reset release.
- Counters are sized by $clog2 of their maximum value. Counters never wrap: each is cleared on every state change.

Optional Feature:
Macro UART_RX_TIMEOUT_EN.
- Defined: an idle counter runs whenever byte count ≠ 0 and the FSM is in IDLE, and clears on any start edge. On reaching TIMEOUT_BITS*CLOCK_PER_BIT cycles, the block clears the partial word and byte count and pulses timeout for one cycle. This resynchronizes word alignment after a dropped byte.
- Undefined: no idle counter is built, timeout is tied 0, and a partial word waits indefinitely.

Decomposition:
- Shared package uart_pkg holds:
  - UART_DATA_BIT=8.
  - The bit-FSM state enum {IDLE, START, DATA, STOP, BREAK}.
  - A helper function for counter width.
- One sub-module, uart_rx, is natural: the synchronizer plus bit-level FSM. Its outputs are byte_valid, byte_data[7:0] and frame_error. uart_rx_top holds word packing and the timeout logic.

Test Plan:
1. DATA_WIDTH=16, CLOCK_PER_BIT=16. Send 0xA5 then 0x3C -> one data_valid pulse with data_out=0xA53C; frame_error=0.
2. Low glitch of 6 cycles on an idle line -> no strobes; the next frame 0x12, 0x34 yields data_out=0x1234.
3. Send 0x55 with the stop bit held low for 2 bit-times, then 0xAA, 0xBB -> one frame_error pulse, then data_out=0xAABB.
4. Assert a_reset_n low during bit 4 of the second byte, release, then send 0xDE, 0xAD -> all outputs 0 during reset; then data_out=0xDEAD, with no stale bytes.
5. Send 10 words back-to-back with zero idle time, incrementing from 0x0001 -> 10 data_valid pulses in order, values 0x0001..0x000A.
6. With UART_RX_TIMEOUT_EN and TIMEOUT_BITS=4: send 0x11, idle 5 bit-times, then send 0x22, 0x33 -> timeout pulse after 4 bit-times; then data_out=0x2233.
